// File: rtl/matmul_pkg.sv
// matmul_pkg: state encoding and widths shared by the matmul
// sequencer, operand storage, MAC and output blocks.
package matmul_pkg;

  localparam int N_DEF  = 3;
  localparam int AW_DEF = $clog2(N_DEF * N_DEF);
  localparam int OP_W   = 8;
  localparam int C_W    = 18;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/matmul_idx_counter.sv
// matmul_idx_counter: nested i/j/k walk over C in row-major order,
// with the derived A/B/C element indices.
module matmul_idx_counter
  import matmul_pkg::*;
#(
  parameter  int N  = N_DEF,
  localparam int AW = $clog2(N * N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          inc_k_i,
  input  logic          next_el_i,
  output logic          k_first_o,
  output logic          k_last_o,
  output logic          el_last_o,
  output logic [AW-1:0] a_idx_o,
  output logic [AW-1:0] b_idx_o,
  output logic [AW-1:0] c_idx_o
);

  localparam logic [AW-1:0] NV = AW'(N);
  localparam logic [AW-1:0] NL = AW'(N - 1);

  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] j_q, j_d;
  logic [AW-1:0] k_q, k_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    unique case (1'b1)
      clr_i: begin
        i_d = '0;
        j_d = '0;
        k_d = '0;
      end
      next_el_i: begin
        k_d = '0;
        j_d = (j_q == NL) ? '0 : j_q + 1'b1;
        if (j_q == NL)
          i_d = (i_q == NL) ? '0 : i_q + 1'b1;
      end
      inc_k_i: k_d = (k_q == NL) ? '0 : k_q + 1'b1;
      default: ;
    endcase
  end

  assign k_first_o = (k_q == '0);
  assign k_last_o  = (k_q == NL);
  assign el_last_o = (i_q == NL) && (j_q == NL);

  assign a_idx_o = i_q * NV + k_q;
  assign b_idx_o = k_q * NV + j_q;
  assign c_idx_o = i_q * NV + j_q;

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: drives one shared MAC through an NxN matrix
// multiply, issuing operand reads and C writebacks.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter  int N       = N_DEF,
  parameter  int MAC_LAT = 1,
  localparam int AW      = $clog2(N * N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          op_ready,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          c_wr,
  output logic [AW-1:0] c_addr,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] DRAIN_END = 3'(MAC_LAT - 1);

  state_e        state_q, state_d;
  logic [2:0]    drain_q, drain_d;
  logic [AW-1:0] a_addr_q, a_addr_d;
  logic [AW-1:0] b_addr_q, b_addr_d;
  logic [AW-1:0] c_addr_q, c_addr_d;
  logic          mac_en_q, mac_en_d;
  logic          mac_clr_q, mac_clr_d;
  logic          c_wr_q, c_wr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          clr, inc_k, next_el;
  logic          k_first, k_last, el_last;
  logic [AW-1:0] a_idx, b_idx, c_idx;
  logic          run;

  matmul_idx_counter #(.N(N)) u_idx (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (clr),
    .inc_k_i   (inc_k),
    .next_el_i (next_el),
    .k_first_o (k_first),
    .k_last_o  (k_last),
    .el_last_o (el_last),
    .a_idx_o   (a_idx),
    .b_idx_o   (b_idx),
    .c_idx_o   (c_idx)
  );

  assign run = (state_q == ISSUE) || (state_q == DRAIN)
            || (state_q == WRITE);

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    a_addr_d  = a_addr_q;
    b_addr_d  = b_addr_q;
    c_addr_d  = c_addr_q;
    mac_en_d  = 1'b0;
    mac_clr_d = 1'b0;
    c_wr_d    = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    clr       = 1'b0;
    inc_k     = 1'b0;
    next_el   = 1'b0;
    // abort outranks every in-run action, including a pending write
    if (run && abort) begin
      state_d = IDLE;
      drain_d = '0;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (start) state_d = ISSUE;
        ISSUE: begin
          busy_d = 1'b1;
          if (op_ready) begin
            mac_en_d  = 1'b1;
            mac_clr_d = k_first;
            a_addr_d  = a_idx;
            b_addr_d  = b_idx;
            inc_k     = 1'b1;
            if (k_last) begin
              state_d = DRAIN;
              drain_d = '0;
            end
          end
        end
        DRAIN: begin
          busy_d = 1'b1;
          if (drain_q == DRAIN_END) begin
            state_d = WRITE;
            drain_d = '0;
          end else begin
            drain_d = drain_q + 3'd1;
          end
        end
        WRITE: begin
          busy_d   = 1'b1;
          c_wr_d   = 1'b1;
          c_addr_d = c_idx;
          next_el  = 1'b1;
          state_d  = el_last ? DONE : ISSUE;
        end
        DONE: begin
          done_d  = 1'b1;
          clr     = 1'b1;
          state_d = start ? ISSUE : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      drain_q   <= '0;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      c_addr_q  <= '0;
      mac_en_q  <= 1'b0;
      mac_clr_q <= 1'b0;
      c_wr_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      a_addr_q  <= a_addr_d;
      b_addr_q  <= b_addr_d;
      c_addr_q  <= c_addr_d;
      mac_en_q  <= mac_en_d;
      mac_clr_q <= mac_clr_d;
      c_wr_q    <= c_wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign a_addr  = a_addr_q;
  assign b_addr  = b_addr_q;
  assign c_addr  = c_addr_q;
  assign mac_en  = mac_en_q;
  assign mac_clr = mac_clr_q;
  assign c_wr    = c_wr_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed tables plus randomized op_ready/start
// against a schedule model, on MAC_LAT=1 (u0) and MAC_LAT=3 (u1).
module tb_matmul_sequencer;

  localparam int N    = 3;
  localparam int AW   = $clog2(N * N);
  localparam int MAXC = 300;

  typedef struct {
    bit rdy;
    bit en;
    bit clr;
    int a;
    int b;
    bit cwr;
    bit busy;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic op_ready = 1'b0;

  logic [AW-1:0] a0, b0, c0, a1, b1, c1;
  logic en0, clr0, wr0, busy0, done0;
  logic en1, clr1, wr1, busy1, done1;

  matmul_sequencer #(.N(N), .MAC_LAT(1)) u0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .op_ready(op_ready), .a_addr(a0), .b_addr(b0),
    .mac_en(en0), .mac_clr(clr0), .c_wr(wr0), .c_addr(c0),
    .busy(busy0), .done(done0)
  );

  matmul_sequencer #(.N(N), .MAC_LAT(3)) u1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .op_ready(op_ready), .a_addr(a1), .b_addr(b1),
    .mac_en(en1), .mac_clr(clr1), .c_wr(wr1), .c_addr(c1),
    .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int e_en[2][MAXC];
  int e_clr[2][MAXC];
  int e_a[2][MAXC];
  int e_b[2][MAXC];
  int e_cwr[2][MAXC];
  int e_c[2][MAXC];
  int e_busy[2][MAXC];
  int e_done[2][MAXC];
  bit rdy_v[MAXC];
  bit st_v[MAXC];
  int first_done[2], last_done[2], first_cwr[2], last_cwr[2];
  vec_t tbl[8];

  task automatic chk(input string nm, input int cyc,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] sig(input int d, input int w);
    logic [31:0] r;
    r = '0;
    case (w)
      0: r = 32'(d == 0 ? en0 : en1);
      1: r = 32'(d == 0 ? clr0 : clr1);
      2: r = 32'(d == 0 ? a0 : a1);
      3: r = 32'(d == 0 ? b0 : b1);
      4: r = 32'(d == 0 ? wr0 : wr1);
      5: r = 32'(d == 0 ? c0 : c1);
      6: r = 32'(d == 0 ? busy0 : busy1);
      default: r = 32'(d == 0 ? done0 : done1);
    endcase
    return r;
  endfunction

  // Lays one run starting at cycle s onto the expected timeline;
  // returns the done cycle.
  function automatic int sched(input int d, input int s);
    int t;
    int lat;
    t = s;
    lat = (d == 0) ? 1 : 3;
    for (int e = 0; e < N * N; e++) begin
      for (int k = 0; k < N; k++) begin
        t++;
        while (t < MAXC - 1 && !rdy_v[t]) t++;
        if (t < MAXC) begin
          e_en[d][t]  = 1;
          e_clr[d][t] = (k == 0) ? 1 : 0;
          e_a[d][t]   = (e / N) * N + k;
          e_b[d][t]   = k * N + (e % N);
        end
      end
      t += lat + 1;
      if (t < MAXC) begin
        e_cwr[d][t] = 1;
        e_c[d][t]   = e;
      end
    end
    for (int c = s + 1; c <= t && c < MAXC; c++) e_busy[d][c] = 1;
    if (t + 1 < MAXC) e_done[d][t + 1] = 1;
    return t + 1;
  endfunction

  task automatic build(input int len);
    int nxt;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < MAXC; c++) begin
        e_en[d][c] = 0; e_clr[d][c] = 0; e_a[d][c] = 0;
        e_b[d][c] = 0; e_cwr[d][c] = 0; e_c[d][c] = 0;
        e_busy[d][c] = 0; e_done[d][c] = 0;
      end
      nxt = 0;
      for (int c = 0; c < len; c++)
        if (st_v[c] && c >= nxt) nxt = sched(d, c);
      for (int c = 1; c < MAXC; c++)
        if (e_en[d][c] == 0) begin
          e_a[d][c] = e_a[d][c - 1];
          e_b[d][c] = e_b[d][c - 1];
        end
    end
  endtask

  task automatic apply_run(input int len);
    build(len);
    for (int d = 0; d < 2; d++) begin
      first_done[d] = -1; last_done[d] = -1;
      first_cwr[d] = -1;  last_cwr[d] = -1;
    end
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      start = st_v[c];
      op_ready = rdy_v[c];
      abort = 1'b0;
      @(posedge clk);
      #1;
      if (c > 0) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("u%0d.mac_en", d), c, sig(d, 0), e_en[d][c]);
          chk($sformatf("u%0d.mac_clr", d), c, sig(d, 1), e_clr[d][c]);
          chk($sformatf("u%0d.a_addr", d), c, sig(d, 2), e_a[d][c]);
          chk($sformatf("u%0d.b_addr", d), c, sig(d, 3), e_b[d][c]);
          chk($sformatf("u%0d.c_wr", d), c, sig(d, 4), e_cwr[d][c]);
          if (e_cwr[d][c] != 0)
            chk($sformatf("u%0d.c_addr", d), c, sig(d, 5), e_c[d][c]);
          chk($sformatf("u%0d.busy", d), c, sig(d, 6), e_busy[d][c]);
          chk($sformatf("u%0d.done", d), c, sig(d, 7), e_done[d][c]);
          if (sig(d, 7) == 1) begin
            if (first_done[d] < 0) first_done[d] = c;
            last_done[d] = c;
          end
          if (sig(d, 4) == 1) begin
            if (first_cwr[d] < 0) first_cwr[d] = c;
            last_cwr[d] = c;
          end
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    op_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 8; w++)
        chk($sformatf("u%0d.reset_out%0d", d, w), 0, sig(d, w), 0);
  endtask

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      rdy_v[c] = 1'b1;
      st_v[c] = 1'b0;
    end
  endtask

  initial begin
    int flag;
    int dc;

    tbl[0] = '{1, 1, 1, 0, 0, 0, 1};
    tbl[1] = '{1, 1, 0, 1, 3, 0, 1};
    tbl[2] = '{0, 0, 0, 1, 3, 0, 1};
    tbl[3] = '{0, 0, 0, 1, 3, 0, 1};
    tbl[4] = '{1, 1, 0, 2, 6, 0, 1};
    tbl[5] = '{1, 0, 0, 2, 6, 0, 1};
    tbl[6] = '{1, 0, 0, 2, 6, 1, 1};
    tbl[7] = '{1, 1, 1, 0, 1, 0, 1};

    // nominal run
    do_reset();
    clear_stim();
    st_v[0] = 1'b1;
    apply_run(70);
    chk("nom_first_cwr", 0, first_cwr[0], 5);
    chk("nom_last_cwr", 0, last_cwr[0], 45);
    chk("nom_done", 0, first_done[0], 46);
    chk("lat3_first_cwr", 0, first_cwr[1], 7);
    chk("lat3_last_cwr", 0, last_cwr[1], 63);
    chk("lat3_done", 0, first_done[1], 64);

    // start ignored while busy, restart from DONE
    do_reset();
    clear_stim();
    st_v[0] = 1'b1;
    st_v[20] = 1'b1;
    st_v[46] = 1'b1;
    apply_run(100);
    chk("restart_first_done", 0, first_done[0], 46);
    chk("restart_second_done", 0, last_done[0], 92);
    chk("lat3_ignored_done", 0, last_done[1], 64);

    // stall table on u0
    do_reset();
    @(negedge clk);
    start = 1'b1;
    op_ready = 1'b1;
    @(posedge clk);
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      start = 1'b0;
      op_ready = tbl[v].rdy;
      @(posedge clk);
      #1;
      chk("stall.mac_en", v + 1, en0, tbl[v].en);
      chk("stall.mac_clr", v + 1, clr0, tbl[v].clr);
      chk("stall.a_addr", v + 1, a0, tbl[v].a);
      chk("stall.b_addr", v + 1, b0, tbl[v].b);
      chk("stall.c_wr", v + 1, wr0, tbl[v].cwr);
      chk("stall.busy", v + 1, busy0, tbl[v].busy);
    end
    dc = -1;
    for (int c = 9; c < 100; c++) begin
      @(negedge clk);
      op_ready = 1'b1;
      @(posedge clk);
      #1;
      if (done0 && dc < 0) dc = c;
    end
    chk("stall_done_cycle", 0, dc, 48);

    // abort during a WRITE cycle
    do_reset();
    @(negedge clk);
    start = 1'b1;
    op_ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (c == 20);
      @(posedge clk);
      #1;
      if (c == 20) chk("abort_cwr", c, wr0, 0);
      if (c == 21) begin
        chk("abort_busy", c, busy0, 0);
        chk("abort_mac_en", c, en0, 0);
        chk("abort_busy_u1", c, busy1, 0);
      end
    end
    flag = 0;
    for (int c = 22; c < 80; c++) begin
      @(negedge clk);
      abort = 1'b0;
      @(posedge clk);
      #1;
      if (wr0 || done0 || wr1 || done1 || busy0 || busy1) flag++;
    end
    chk("abort_quiet", 0, flag, 0);
    // start and abort together while idle: start wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk);
    #1;
    chk("restart_mac_en", 0, en0, 1);
    chk("restart_a_addr", 0, a0, 0);
    chk("restart_b_addr", 0, b0, 0);
    chk("restart_mac_clr", 0, clr0, 1);

    // asynchronous reset pulse mid-cycle
    do_reset();
    @(negedge clk);
    start = 1'b1;
    op_ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
    end
    #2;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 8; w++)
        chk($sformatf("u%0d.async_rst_out%0d", d, w), 12, sig(d, w), 0);
    #1;
    reset = 1'b0;
    flag = 0;
    for (int c = 13; c < 80; c++) begin
      @(negedge clk);
      @(posedge clk);
      #1;
      if (wr0 || done0 || wr1 || done1 || busy0 || en0) flag++;
    end
    chk("rst_quiet", 0, flag, 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_idle_start", 0, en0, 1);
    chk("rst_idle_a", 0, a0, 0);

    // randomized op_ready and start pulses
    for (int it = 0; it < 3; it++) begin
      do_reset();
      for (int c = 0; c < MAXC; c++) begin
        rdy_v[c] = ($urandom_range(0, 3) != 0);
        st_v[c] = (c == 0) || ($urandom_range(0, 24) == 0);
      end
      apply_run(260);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
Controller that runs the 3x3 matrix multiply through one shared 8x8 multiply-accumulate (MAC) unit, instead of a full parallel array.
- Walks the output elements C[i][j] in row-major order and, for each, the inner index k.
- Drives operand read addresses into the A/B register files, MAC clear/enable strobes, and C writeback.
- Sits between the top-level INPUT/COMPUTE/OUTPUT FSM (start/done handshake) and the MAC plus A/B/C storage.

Parameters:
N, 3, matrix dimension (square NxN); supported range 2..4.
MAC_LAT, 1, cycles from a mac_en issue to the accumulator holding the updated sum; range 1..7.
AW, $clog2(N*N), address width for A/B/C element indices; derived localparam, not overridable.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  begin a multiply; sampled in IDLE or DONE only.
abort  in  1  synchronous cancel of a run in progress.
op_ready  in  1  A/B operand storage can be read this cycle; low stalls issue.
a_addr  out  AW  A element index i*N+k, registered.
b_addr  out  AW  B element index k*N+j, registered.
mac_en  out  1  operand pair valid; MAC multiplies and accumulates.
mac_clr  out  1  with mac_en: load the product instead of accumulating (k==0).
c_wr  out  1  write the accumulator to C storage this cycle.
c_addr  out  AW  C element index i*N+j, valid with c_wr.
busy  out  1  run in progress (ISSUE, DRAIN, WRITE).
done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0, counters i=j=k=0, state IDLE. Reset asserted mid-run clears everything immediately. No c_wr or done is produced for the aborted run.
- Cycle numbering: cycle 0 is the clock edge that samples start=1. Cycle n is the n-th edge after it; output values are those after that edge.
- States:
  - IDLE: on start, go to ISSUE.
  - ISSUE: each cycle with op_ready=1, mac_en=1 and the addresses are driven from (i,j,k); then k increments.
    - After issuing k==N-1, go to DRAIN.
    - With op_ready=0: mac_en=0, mac_clr=0, counters and addresses held.
  - DRAIN: wait MAC_LAT cycles (counter), then go to WRITE. op_ready is ignored here.
  - WRITE: one cycle with c_wr=1 and c_addr=i*N+j; k is cleared and (j,i) advance row-major.
    - If the element was (N-1,N-1), go to DONE; otherwise go to ISSUE.
  - DONE: done=1 for one cycle, busy=0, then IDLE. start in DONE begins a new run next cycle, with no IDLE bubble.
- mac_clr=1 only when mac_en=1 and k==0.
- When mac_en=0 the addresses hold their last value. After DONE or abort, the counters return to 0.
- Per-element cost is N+MAC_LAT+1 cycles with op_ready held high. Element e writes at cycle (e+1)*(N+MAC_LAT+1). done is at N*N*(N+MAC_LAT+1)+1 (46 for the defaults).
- Each op_ready=0 cycle in ISSUE adds exactly one cycle.
- start while busy=1 is ignored.
- abort while busy: next cycle is IDLE with all strobes 0, no done.
  - abort wins over a same-cycle WRITE, so that c_wr is suppressed.
  - abort in IDLE or DONE has no effect.
  - abort and start asserted together in IDLE: start wins.
- Arithmetic: indices are computed in AW bits, with no wrap beyond N*N-1.

Decomposition:
- Shared package matmul_pkg holds the state enum (IDLE, ISSUE, DRAIN, WRITE, DONE), the default N, AW and data widths (8-bit operands, 18-bit C), shared with the input, output and mult blocks.
- One sub-module, matmul_idx_counter: the nested i/j/k counter with increment, clear and last-element flags. It also computes a_addr, b_addr and c_addr.
- The FSM and DRAIN counter stay in matmul_sequencer.

Test Plan:
- Nominal: defaults, op_ready=1, start pulse at cycle 0.
  - a_addr reads 0,1,2 and b_addr reads 0,3,6 on cycles 1-3; mac_clr is set only on cycle 1.
  - c_wr occurs at cycles 5,10,...,45 with c_addr 0..8.
  - done is high on cycle 46 only; busy is high on cycles 1-45.
- Stall: op_ready=0 on cycles 2-3.
  - mac_en is 0 on those cycles and a_addr is held at 1.
  - First c_wr moves to cycle 7; done moves to 48.
- start handling:
  - start pulsed at cycle 20 is ignored; done is still at 46.
  - start at cycle 46 (DONE) gives mac_en with a_addr=0 at cycle 47 and a second done at 92.
- Abort at cycle 20 (a WRITE cycle):
  - c_wr=0 at cycle 20 and busy=0 from cycle 21.
  - No done is produced.
  - A new start gives a_addr=0, b_addr=0, mac_clr=1.
- Async reset pulse between edges at cycle 12: all outputs 0 immediately, no further c_wr, no done; state is IDLE after release.
- MAC_LAT=3: element 0 c_wr at cycle 7, element 8 at cycle 63, done at 64.
